// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree with a group accumulator.
//
// Each beat carries NUM_PP signed partial products. They are reduced by a
// binary tree with one register per level. The tree sum then enters an
// accumulator that either sums consecutive beats until in_last, or treats
// every beat as its own group when acc_en=0.
//
// Handshake: valid-only stream. A beat is accepted on every rising edge
// where in_valid=1. There is no ready and no backpressure. out_valid is a
// one-cycle pulse, and out_data/out_ovf hold their values until the next
// pulse.
//
// Build option: define ADDER_TREE_ACC_SAT_EN to clamp an overflowing
// accumulator to the signed ACC_W limits. Without it (the default), the
// accumulator wraps in two's complement. out_ovf behaves the same in both
// builds.
module adder_tree_acc #(
  parameter int NUM_PP = 9,
  parameter int PP_W   = 16,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic                     acc_en,
  input  logic [NUM_PP*PP_W-1:0]   pp_bus,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam int LEVELS = (NUM_PP > 1) ? $clog2(NUM_PP) : 0;
  localparam int SUM_W  = PP_W + LEVELS;

  // Number of live operands at a given tree level (level 0 = raw inputs).
  function automatic int level_cnt(input int lvl);
    int n;
    n = NUM_PP;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  if (NUM_PP < 1 || NUM_PP > 32) begin : g_bad_num_pp
    $error("adder_tree_acc: NUM_PP must be in 1..32");
  end
  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("adder_tree_acc: ACC_W must be at least PP_W + LEVELS");
  end

  // Tree levels. Every node is carried at SUM_W bits. Sign-extending an
  // operand all the way up front gives the same value as extending it by
  // one bit per level. A pair sum at level l fits in PP_W+l bits, so no
  // level can overflow. An odd leftover operand moves to the next level
  // unchanged.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = level_cnt(l);
    logic signed [SUM_W-1:0] node [N];
    logic v;
    logic lst;
    logic en;

    if (l == 0) begin : g_src
      for (genvar j = 0; j < N; j++) begin : g_pp
        assign node[j] = SUM_W'($signed(pp_bus[j*PP_W +: PP_W]));
      end
      assign v   = in_valid;
      assign lst = in_last;
      assign en  = acc_en;
    end else begin : g_add
      localparam int NP = level_cnt(l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2*j + 1 < NP) begin : g_pair
          // Register the sum of an adjacent operand pair.
          always_ff @(posedge clk or posedge rst)
            if (rst) node[j] <= '0;
            else     node[j] <= g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
        end else begin : g_pass
          // Register an odd leftover operand so it stays aligned.
          always_ff @(posedge clk or posedge rst)
            if (rst) node[j] <= '0;
            else     node[j] <= g_lvl[l-1].node[2*j];
        end
      end
      // Beat control travels alongside the data, one stage per level.
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v   <= 1'b0;
          lst <= 1'b0;
          en  <= 1'b0;
        end else begin
          v   <= g_lvl[l-1].v;
          lst <= g_lvl[l-1].lst;
          en  <= g_lvl[l-1].en;
        end
    end
  end

  // Accumulator group state. FIRST means the next valid beat opens a new
  // group.
  typedef enum logic {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } grp_state_t;

  grp_state_t              state;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_ovf;

  logic                    tree_v;
  logic                    closing;
  logic signed [ACC_W-1:0] tree_sum;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   raw;
  logic                    beat_ovf;
  logic                    grp_ovf;
  logic signed [ACC_W-1:0] acc_next;

`ifdef ADDER_TREE_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Next accumulator value, overflow detection and group-close decision.
  always_comb begin
    tree_v   = g_lvl[LEVELS].v;
    closing  = g_lvl[LEVELS].lst | ~g_lvl[LEVELS].en;
    tree_sum = ACC_W'(g_lvl[LEVELS].node[0]);
    base     = (state == FIRST) ? '0 : acc;
    raw      = (ACC_W+1)'(base) + (ACC_W+1)'(tree_sum);
    // The sum leaves the signed ACC_W range exactly when the two top bits
    // of the one-bit-wider result differ.
    beat_ovf = raw[ACC_W] ^ raw[ACC_W-1];
    grp_ovf  = beat_ovf | ((state == ACCUM) & acc_ovf);
`ifdef ADDER_TREE_ACC_SAT_EN
    if (beat_ovf) acc_next = raw[ACC_W] ? ACC_MIN : ACC_MAX;
    else          acc_next = raw[ACC_W-1:0];
`else
    acc_next = raw[ACC_W-1:0];
`endif
  end

  // Group accumulation, result register and the one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= FIRST;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_v) begin
        if (closing) begin
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_ovf   <= grp_ovf;
          acc       <= '0;
          acc_ovf   <= 1'b0;
          state     <= FIRST;
        end else begin
          acc       <= acc_next;
          acc_ovf   <= grp_ovf;
          state     <= ACCUM;
        end
      end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Testbench for adder_tree_acc (NUM_PP=9, PP_W=16, ACC_W=20).
// Expected group results go into a queue when the closing beat is driven.
// A monitor pops them when out_valid fires and checks data, overflow and
// arrival cycle.
module tb_adder_tree_acc;

  localparam int NUM_PP = 9;
  localparam int PP_W   = 16;
  localparam int ACC_W  = 20;
  localparam int BW     = NUM_PP * PP_W;
  localparam int LAT    = 5;
  localparam int EW     = 1 + ACC_W + 32;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic in_valid = 1'b0;
  logic in_last  = 1'b0;
  logic acc_en   = 1'b0;
  logic [BW-1:0] pp_bus = '0;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ovf;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  // Entry format: {ovf, data, due_cycle}.
  logic [EW-1:0] exp_q[$];

  longint m_acc   = 0;
  logic   m_first = 1'b1;
  logic   m_ov    = 1'b0;

  typedef struct {
    logic [BW-1:0] bus;
    logic          last;
    logic          en;
    longint        exp_data;
    logic          exp_ovf;
  } vec_t;

  vec_t tbl[6];

  adder_tree_acc #(.NUM_PP(NUM_PP), .PP_W(PP_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_last  (in_last),
    .acc_en   (acc_en),
    .pp_bus   (pp_bus),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [BW-1:0] all_pp(input logic signed [PP_W-1:0] v);
    logic [BW-1:0] b;
    for (int k = 0; k < NUM_PP; k++) b[k*PP_W +: PP_W] = v;
    return b;
  endfunction

  function automatic logic [BW-1:0] one_pp(input logic signed [PP_W-1:0] v);
    logic [BW-1:0] b;
    b = '0;
    b[PP_W-1:0] = v;
    return b;
  endfunction

  function automatic longint bus_sum(input logic [BW-1:0] b);
    longint s;
    logic signed [PP_W-1:0] p;
    s = 0;
    for (int k = 0; k < NUM_PP; k++) begin
      p = b[k*PP_W +: PP_W];
      s += p;
    end
    return s;
  endfunction

  // Apply a beat now and update the group model. On a closing beat, queue
  // either the given expectation or the model's result.
  task automatic set_beat(input logic [BW-1:0] bus, input logic v, input logic last,
                          input logic en, input logic use_exp, input longint x_data,
                          input logic x_ovf);
    longint a;
    logic ov, g_ov;
    logic signed [ACC_W-1:0] r;
    pp_bus   = bus;
    in_valid = v;
    in_last  = last;
    acc_en   = en;
    if (v) begin
      a    = (m_first ? longint'(0) : m_acc) + bus_sum(bus);
      ov   = (a > ACC_MAX) || (a < ACC_MIN);
      g_ov = ov | (!m_first && m_ov);
`ifdef ADDER_TREE_ACC_SAT_EN
      if (a > ACC_MAX) a = ACC_MAX;
      else if (a < ACC_MIN) a = ACC_MIN;
`endif
      r = a[ACC_W-1:0];
      if (last || !en) begin
        if (use_exp) exp_q.push_back({x_ovf, x_data[ACC_W-1:0], 32'(cyc + LAT)});
        else         exp_q.push_back({g_ov, r, 32'(cyc + LAT)});
        m_first = 1'b1;
        m_acc   = 0;
        m_ov    = 1'b0;
      end else begin
        m_first = 1'b0;
        m_acc   = r;
        m_ov    = g_ov;
      end
    end
  endtask

  task automatic beat(input logic [BW-1:0] bus, input logic last, input logic en,
                      input logic use_exp, input longint x_data, input logic x_ovf);
    @(negedge clk);
    set_beat(bus, 1'b1, last, en, use_exp, x_data, x_ovf);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      set_beat('0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
  endtask

  // Assert reset between edges and check that the outputs clear before any
  // clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_beat('0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_first = 1'b1;
    m_acc   = 0;
    m_ov    = 1'b0;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: sample outputs on the falling edge.
  task automatic monitor();
    logic [EW-1:0] e;
    logic signed [ACC_W-1:0] ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got a pulse with data %0d, expected none (cycle %0d)",
                     out_data, cyc);
          end else begin
            e  = exp_q.pop_front();
            ed = e[ACC_W+31:32];
            check("out_data", out_data, ed);
            check("out_ovf", out_ovf, e[EW-1]);
            check("latency_cycle", cyc, e[31:0]);
          end
        end else if (exp_q.size() != 0 && int'(exp_q[0][31:0]) < cyc) begin
          n_vec++;
          n_bad++;
          $display("FAIL missing_out_valid: got no pulse, expected one at cycle %0d (now %0d)",
                   int'(exp_q[0][31:0]), cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    logic [BW-1:0] b;
    logic [BW-1:0] rb;

    // Single-beat vectors: {bus, last, en, expected data, expected ovf}.
    tbl[0] = '{all_pp(16'sd1), 1'b1, 1'b1, 9, 1'b0};
    tbl[1] = '{all_pp(-16'sd32768), 1'b1, 1'b1, -294912, 1'b0};
    tbl[2] = '{all_pp(16'sd32767), 1'b1, 1'b1, 294903, 1'b0};
    tbl[3] = '{one_pp(-16'sd1), 1'b0, 1'b0, -1, 1'b0};
    for (int k = 0; k < NUM_PP; k++) b[k*PP_W +: PP_W] = PP_W'(k - 4);
    tbl[4] = '{b, 1'b1, 1'b0, 0, 1'b0};
    for (int k = 0; k < NUM_PP; k++) b[k*PP_W +: PP_W] = (k % 2 == 0) ? 16'h7fff : 16'h8000;
    tbl[5] = '{b, 1'b1, 1'b1, 32763, 1'b0};

    fork
      monitor();
    join_none

    // Power-on reset.
    #1;
    check("por_out_valid", out_valid, 0);
    check("por_out_data", out_data, 0);
    check("por_out_ovf", out_ovf, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table vectors, applied back to back.
    for (int i = 0; i < 6; i++)
      beat(tbl[i].bus, tbl[i].last, tbl[i].en, 1'b1, tbl[i].exp_data, tbl[i].exp_ovf);
    drain();

    // Three-beat group of 100, then an immediate acc_en=0 beat of 7.
    beat(one_pp(16'sd100), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(one_pp(16'sd100), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(one_pp(16'sd100), 1'b1, 1'b1, 1'b1, 300, 1'b0);
    beat(one_pp(16'sd7), 1'b0, 1'b0, 1'b1, 7, 1'b0);
    drain();

    // Overflow: positive, sticky across a recovering beat, negative, then
    // a clean group.
`ifdef ADDER_TREE_ACC_SAT_EN
    beat(all_pp(16'sd32767), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(16'sd32767), 1'b1, 1'b1, 1'b1, 524287, 1'b1);
    beat(all_pp(16'sd32767), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(16'sd32767), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(-16'sd32768), 1'b1, 1'b1, 1'b1, 229375, 1'b1);
    beat(all_pp(-16'sd32768), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(-16'sd32768), 1'b1, 1'b1, 1'b1, -524288, 1'b1);
`else
    beat(all_pp(16'sd32767), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(16'sd32767), 1'b1, 1'b1, 1'b1, -458770, 1'b1);
    beat(all_pp(16'sd32767), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(16'sd32767), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(-16'sd32768), 1'b1, 1'b1, 1'b1, 294894, 1'b1);
    beat(all_pp(-16'sd32768), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(all_pp(-16'sd32768), 1'b1, 1'b1, 1'b1, 458752, 1'b1);
`endif
    beat(one_pp(16'sd1), 1'b1, 1'b1, 1'b1, 1, 1'b0);
    drain();

    // Bubbles inside a group; the result must then hold while idle.
    beat(one_pp(16'sd5), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(3);
    beat(one_pp(16'sd6), 1'b1, 1'b1, 1'b1, 11, 1'b0);
    drain();
    idle(4);
    check("hold_out_data", out_data, 11);

    // Reset mid-group: one beat already accumulated, one still in flight.
    // The first beat after release goes in on the first rising edge.
    beat(one_pp(16'sd50), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    beat(one_pp(16'sd50), 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(3);
    do_reset();
    set_beat(one_pp(16'sd10), 1'b1, 1'b1, 1'b1, 1'b1, 10, 1'b0);
    drain();
    idle(6);

    // Random traffic checked against the group model.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NUM_PP; k++) rb[k*PP_W +: PP_W] = PP_W'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) idle(1);
      else beat(rb, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 1'b0, 0, 1'b0);
    end
    beat(one_pp(16'sd3), 1'b1, 1'b1, 1'b0, 0, 1'b0);
    drain();
    idle(2);

    while (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got no result, expected one due at cycle %0d",
               int'(exp_q[0][31:0]));
      void'(exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_acc.md
ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 SHALL have parameter NUM_PP, default 9, number of signed partial products summed per beat (1..32).
REQ-002 SHALL have parameter PP_W, default 16, width of each partial product.
REQ-003 SHALL have parameter ACC_W, default 24, accumulator and result width; elaboration error if ACC_W < SUM_W.
REQ-004 SHALL derive LEVELS = ceil(log2(NUM_PP)) (0 when NUM_PP=1) and SUM_W = PP_W + LEVELS.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  partial-product beat valid.
REQ-008 SHALL have port in_last  input  1  beat closes the accumulation group; qualified by in_valid.
REQ-009 SHALL have port acc_en  input  1  1 = accumulate across beats until in_last; 0 = every beat is its own group.
REQ-010 SHALL have port pp_bus  input  NUM_PP*PP_W  flattened signed partial products, pp k at bits [k*PP_W +: PP_W].
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port out_data  output  ACC_W  signed group result.
REQ-013 SHALL have port out_ovf  output  1  group overflowed ACC_W; valid with out_valid.

Function
REQ-014 SHALL sum pairs per tree level with sign extension by one bit per level; odd leftover operand passes to next level sign-extended.
REQ-015 SHALL register every tree level; in_valid, in_last, acc_en travel in a matching valid pipeline.
REQ-016 SHALL present out_valid for a beat exactly LEVELS+1 cycles after its in_valid (5 cycles at NUM_PP=9).
REQ-017 SHALL accept one beat per cycle, no backpressure; bubbles (in_valid=0) leave accumulator unchanged.
REQ-018 SHALL use group state FIRST/ACCUM: FIRST -> ACCUM on valid non-closing beat; any closing beat -> FIRST.
REQ-019 Closing beat SHALL be in_last=1 or acc_en=0 (sampled with the beat).
REQ-020 Per valid beat SHALL compute acc_next = (FIRST ? 0 : acc) + sign-extended tree sum.
REQ-021 On closing beat SHALL load out_data = acc_next, pulse out_valid, clear acc to 0.
REQ-022 SHALL set out_ovf if any beat in the group exceeded signed ACC_W range; sticky within the group, cleared at group start.
REQ-023 Back-to-back groups with no bubble SHALL be handled: new group starts from 0 on the cycle after closing beat.
REQ-024 out_data SHALL hold its value between out_valid pulses.

Reset
REQ-025 rst=1 SHALL asynchronously clear all tree registers, valid pipeline, acc, state (to FIRST), out_valid, out_data, out_ovf to 0.
REQ-026 Beats in flight at reset SHALL be discarded; no out_valid for them after release.
REQ-027 First beat accepted on the first rising edge with rst=0.

Configuration
REQ-028 Macro ADDER_TREE_ACC_SAT_EN defined: overflowing acc_next SHALL clamp to max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) and stay clamped-arithmetic for the group.
REQ-029 Macro undefined: acc_next SHALL wrap two's complement; out_ovf behaves identically in both builds.

Verification
REQ-030 Single beat: NUM_PP=9, all pp=1, in_last=1 -> out_data=9, out_ovf=0, out_valid exactly 5 cycles later.
REQ-031 Minimum: all pp=-32768, in_last=1 -> out_data=-294912, out_ovf=0.
REQ-032 Group: 3 consecutive beats summing 100 each, in_last on third -> one out_valid, out_data=300; next beat immediately after with acc_en=0, sum 7 -> out_data=7 next cycle.
REQ-033 Overflow ACC_W=20: two beats all pp=32767 (sum 294903 each) -> SAT build out_data=524287, out_ovf=1; wrap build out_data=-458770, out_ovf=1.
REQ-034 Reset mid-group: 2 beats of 50 accumulated, rst pulse, then beat 10 with in_last -> out_data=10, no pulse for pre-reset beats.
REQ-035 Bubbles: beats 5, idle 3 cycles, 6 with in_last -> out_data=11, out_valid 5 cycles after final beat.
